// File: rtl/fsm_pattern_detector_if.sv
// fsm_pattern_detector_if: serial-stream and result bundle for the pattern detector
// master drives en/din/clr_cnt and observes results; slave is the detector side
interface fsm_pattern_detector_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W = 8
);
  logic en;
  logic din;
  logic clr_cnt;
  logic y_mealy;
  logic y_moore;
  logic [$clog2(PAT_LEN)-1:0] state_o;
  logic [CNT_W-1:0] match_cnt;
  modport master (output en, din, clr_cnt, input y_mealy, y_moore, state_o, match_cnt);
  modport slave (input en, din, clr_cnt, output y_mealy, y_moore, state_o, match_cnt);
endinterface

// File: rtl/fsm_pattern_detector.sv
// fsm_pattern_detector: serial PATTERN detector with overlap mode, sample enable and saturating match counter
// Ports: clk; reset (sync, active-low); bus.slave: en, din, clr_cnt in; y_mealy, y_moore, state_o, match_cnt out
module fsm_pattern_detector #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  fsm_pattern_detector_if.slave bus
);
  localparam int SW = $clog2(PAT_LEN);
  localparam logic [SW-1:0] S0 = '0;
  localparam logic [SW-1:0] S_LAST = SW'(PAT_LEN - 1);
  // j-th pattern bit in arrival order
  function automatic logic pb(input int j);
    return 1'(PATTERN >> (PAT_LEN - 1 - j));
  endfunction
  // longest pattern prefix that ends the stream (first s pattern bits, then d), excluding a full match
  function automatic int fall(input int s, input logic d);
    int r;
    logic ok;
    r = 0;
    for (int k = 1; k < PAT_LEN && k <= s + 1; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (((s + 1 - k + j) == s ? d : pb(s + 1 - k + j)) != pb(j)) ok = 1'b0;
      if (ok) r = k;
    end
    return r;
  endfunction
  // longest proper prefix of PATTERN that is also its suffix
  function automatic int border();
    int r;
    logic ok;
    r = 0;
    for (int k = 1; k < PAT_LEN; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (pb(PAT_LEN - k + j) != pb(j)) ok = 1'b0;
      if (ok) r = k;
    end
    return r;
  endfunction
  localparam logic [SW-1:0] S_MATCH = OVERLAP ? SW'(border()) : S0;
  logic [SW-1:0] state;
  logic [SW-1:0] tbl [2**SW][2];
  logic match;
  logic moore;
  logic [CNT_W-1:0] cnt;
  // transition table is elaborated as constants; unreachable encodings fall back to S0
  for (genvar s = 0; s < 2**SW; s++) begin : g_s
    for (genvar d = 0; d < 2; d++) begin : g_d
      if (s < PAT_LEN) begin : g_live
        assign tbl[s][d] = SW'(fall(s, 1'(d)));
      end else begin : g_dead
        assign tbl[s][d] = S0;
      end
    end
  end
  assign match = reset & bus.en & (state == S_LAST) & (bus.din == PATTERN[0]);
  assign bus.y_mealy = match;
  assign bus.y_moore = moore;
  assign bus.state_o = state;
  assign bus.match_cnt = cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S0;
      moore <= 1'b0;
      cnt <= '0;
    end else begin
      if (bus.en) begin
        state <= match ? S_MATCH : tbl[state][bus.din];
        moore <= match;
      end
      cnt <= bus.clr_cnt ? CNT_W'(match) : cnt + CNT_W'(match && cnt != '1);
    end
  end
endmodule

// File: tb/tb_fsm_pattern_detector.sv
// tb_fsm_pattern_detector: directed checks of the 1011 detector in overlap, non-overlap and 2-bit counter builds
module tb_fsm_pattern_detector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;
  int tests = 0;
  int fails = 0;
  logic mo, mn, ms;
  logic [7:0] s1 = 8'b10101011;
  logic [6:0] s2 = 7'b1011011;
  int st1 [8] = '{1, 2, 3, 2, 3, 2, 3, 1};
  int st2o [7] = '{1, 2, 3, 1, 2, 3, 1};
  int st2n [7] = '{1, 2, 3, 0, 0, 1, 1};
  always #5 clk = ~clk;
  fsm_pattern_detector_if #(.PAT_LEN(4), .CNT_W(8)) ia ();
  fsm_pattern_detector_if #(.PAT_LEN(4), .CNT_W(8)) ib ();
  fsm_pattern_detector_if #(.PAT_LEN(4), .CNT_W(2)) ic ();
  assign ia.en = en;
  assign ia.din = din;
  assign ia.clr_cnt = clr;
  assign ib.en = en;
  assign ib.din = din;
  assign ib.clr_cnt = clr;
  assign ic.en = en;
  assign ic.din = din;
  assign ic.clr_cnt = clr;
  fsm_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_ov (.clk(clk), .reset(reset), .bus(ia.slave));
  fsm_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (.clk(clk), .reset(reset), .bus(ib.slave));
  fsm_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(ic.slave));
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    din = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic bit_in(input logic d, input logic e, input logic c);
    @(negedge clk);
    din = d;
    en = e;
    clr = c;
    #1;
    mo = ia.y_mealy;
    mn = ib.y_mealy;
    ms = ic.y_mealy;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    din = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ia.state_o !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", ia.state_o); end
    tests++; if (ia.y_moore !== 1'b0) begin fails++; $display("FAIL reset_moore got %b exp 0", ia.y_moore); end
    tests++; if (ia.match_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", ia.match_cnt); end
    tests++; if (ic.match_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt_sat got %0d exp 0", ic.match_cnt); end
    tests++; if (ia.y_mealy !== 1'b0) begin fails++; $display("FAIL reset_mealy got %b exp 0", ia.y_mealy); end
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_overlap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bit_in(s1[7-i], 1'b1, 1'b0);
      tests++; if (mo !== (i == 7)) begin fails++; $display("FAIL ovl_mealy bit %0d got %b exp %b", i + 1, mo, i == 7); end
      tests++; if (ia.state_o !== 2'(st1[i])) begin fails++; $display("FAIL ovl_state bit %0d got %0d exp %0d", i + 1, ia.state_o, st1[i]); end
      tests++; if (ia.y_moore !== (i == 7)) begin fails++; $display("FAIL ovl_moore bit %0d got %b exp %b", i + 1, ia.y_moore, i == 7); end
    end
    tests++; if (ia.match_cnt !== 8'd1) begin fails++; $display("FAIL ovl_cnt got %0d exp 1", ia.match_cnt); end
  endtask
  task automatic test_overlap_vs_non();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in(s2[6-i], 1'b1, 1'b0);
      tests++; if (mo !== (i == 3 || i == 6)) begin fails++; $display("FAIL cmp_mealy_ov bit %0d got %b exp %b", i + 1, mo, i == 3 || i == 6); end
      tests++; if (mn !== (i == 3)) begin fails++; $display("FAIL cmp_mealy_no bit %0d got %b exp %b", i + 1, mn, i == 3); end
      tests++; if (ia.state_o !== 2'(st2o[i])) begin fails++; $display("FAIL cmp_state_ov bit %0d got %0d exp %0d", i + 1, ia.state_o, st2o[i]); end
      tests++; if (ib.state_o !== 2'(st2n[i])) begin fails++; $display("FAIL cmp_state_no bit %0d got %0d exp %0d", i + 1, ib.state_o, st2n[i]); end
    end
    tests++; if (ia.match_cnt !== 8'd2) begin fails++; $display("FAIL cmp_cnt_ov got %0d exp 2", ia.match_cnt); end
    tests++; if (ib.match_cnt !== 8'd1) begin fails++; $display("FAIL cmp_cnt_no got %0d exp 1", ib.match_cnt); end
  endtask
  task automatic test_enable_gaps();
    logic mv_o, mv_n;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in(s2[6-i], 1'b1, 1'b0);
      mv_o = (i == 3 || i == 6);
      mv_n = (i == 3);
      tests++; if (mo !== mv_o) begin fails++; $display("FAIL gap_mealy_ov bit %0d got %b exp %b", i + 1, mo, mv_o); end
      tests++; if (mn !== mv_n) begin fails++; $display("FAIL gap_mealy_no bit %0d got %b exp %b", i + 1, mn, mv_n); end
      for (int g = 0; g < 2; g++) begin
        bit_in(1'b1, 1'b0, 1'b0);
        tests++; if (mo !== 1'b0 || mn !== 1'b0) begin fails++; $display("FAIL gap_mealy_idle bit %0d got %b%b exp 00", i + 1, mo, mn); end
        tests++; if (ia.y_moore !== mv_o || ib.y_moore !== mv_n) begin fails++; $display("FAIL gap_moore_hold bit %0d got %b%b exp %b%b", i + 1, ia.y_moore, ib.y_moore, mv_o, mv_n); end
        tests++; if (ia.state_o !== 2'(st2o[i])) begin fails++; $display("FAIL gap_state_hold bit %0d got %0d exp %0d", i + 1, ia.state_o, st2o[i]); end
      end
    end
    tests++; if (ia.match_cnt !== 8'd2) begin fails++; $display("FAIL gap_cnt_ov got %0d exp 2", ia.match_cnt); end
    tests++; if (ib.match_cnt !== 8'd1) begin fails++; $display("FAIL gap_cnt_no got %0d exp 1", ib.match_cnt); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bit_in(1'b1, 1'b1, 1'b0);
    bit_in(1'b0, 1'b1, 1'b0);
    bit_in(1'b1, 1'b1, 1'b0);
    tests++; if (ia.state_o !== 2'd3) begin fails++; $display("FAIL mid_prefix got %0d exp 3", ia.state_o); end
    @(negedge clk);
    reset = 1'b0;
    din = 1'b1;
    en = 1'b1;
    #1;
    tests++; if (ia.y_mealy !== 1'b0) begin fails++; $display("FAIL mid_mealy_in_reset got %b exp 0", ia.y_mealy); end
    @(posedge clk);
    #1;
    tests++; if (ia.state_o !== 2'd0) begin fails++; $display("FAIL mid_state_reset got %0d exp 0", ia.state_o); end
    tests++; if (ia.match_cnt !== 8'd0) begin fails++; $display("FAIL mid_cnt_reset got %0d exp 0", ia.match_cnt); end
    @(negedge clk);
    reset = 1'b1;
    bit_in(1'b1, 1'b1, 1'b0);
    tests++; if (mo !== 1'b0) begin fails++; $display("FAIL mid_mealy_after got %b exp 0", mo); end
    tests++; if (ia.state_o !== 2'd1) begin fails++; $display("FAIL mid_state_after got %0d exp 1", ia.state_o); end
    tests++; if (ia.match_cnt !== 8'd0) begin fails++; $display("FAIL mid_cnt_after got %0d exp 0", ia.match_cnt); end
  endtask
  task automatic test_saturation();
    do_reset();
    bit_in(1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 5; m++) begin
      bit_in(1'b0, 1'b1, 1'b0);
      bit_in(1'b1, 1'b1, 1'b0);
      bit_in(1'b1, 1'b1, 1'b0);
      tests++; if (ms !== 1'b1) begin fails++; $display("FAIL sat_mealy match %0d got %b exp 1", m + 1, ms); end
      tests++; if (ic.match_cnt !== 2'(m < 3 ? m + 1 : 3)) begin fails++; $display("FAIL sat_cnt match %0d got %0d exp %0d", m + 1, ic.match_cnt, m < 3 ? m + 1 : 3); end
    end
    bit_in(1'b0, 1'b1, 1'b0);
    bit_in(1'b1, 1'b1, 1'b0);
    bit_in(1'b1, 1'b1, 1'b1);
    tests++; if (ms !== 1'b1) begin fails++; $display("FAIL clr_match_mealy got %b exp 1", ms); end
    tests++; if (ic.match_cnt !== 2'd1) begin fails++; $display("FAIL clr_with_match got %0d exp 1", ic.match_cnt); end
    bit_in(1'b0, 1'b1, 1'b1);
    tests++; if (ms !== 1'b0) begin fails++; $display("FAIL clr_only_mealy got %b exp 0", ms); end
    tests++; if (ic.match_cnt !== 2'd0) begin fails++; $display("FAIL clr_only got %0d exp 0", ic.match_cnt); end
  endtask
  initial begin
    test_reset();
    test_overlap();
    test_overlap_vs_non();
    test_enable_gaps();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
